// File: rtl/csr_trap_unit_if.sv
// Write-back commit bundle into the CSR/trap unit, plus its readback and redirect response.
interface csr_trap_unit_if;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CODEW = XLEN - 1;
  localparam int unsigned AW    = 12;

  logic             wb_valid_i;
  logic [XLEN-1:0]  wb_pc_i;
  logic             wb_trap_valid_i;
  logic [CODEW-1:0] wb_trap_code_i;
  logic [XLEN-1:0]  wb_trap_tval_i;
  logic [AW-1:0]    wb_csr_addr_i;
  logic [1:0]       wb_csr_wtype_i;
  logic             wb_csr_access_i;
  logic [XLEN-1:0]  wb_csr_wdata_i;
  logic             wb_is_mret_i;
  logic [XLEN-1:0]  csr_rdata_o;
  logic             redirect_valid_o;
  logic [XLEN-1:0]  redirect_pc_o;
  logic             mie_o;

  modport master (
    output wb_valid_i, wb_pc_i, wb_trap_valid_i, wb_trap_code_i, wb_trap_tval_i,
           wb_csr_addr_i, wb_csr_wtype_i, wb_csr_access_i, wb_csr_wdata_i, wb_is_mret_i,
    input  csr_rdata_o, redirect_valid_o, redirect_pc_o, mie_o
  );

  modport slave (
    input  wb_valid_i, wb_pc_i, wb_trap_valid_i, wb_trap_code_i, wb_trap_tval_i,
           wb_csr_addr_i, wb_csr_wtype_i, wb_csr_access_i, wb_csr_wdata_i, wb_is_mret_i,
    output csr_rdata_o, redirect_valid_o, redirect_pc_o, mie_o
  );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer at commit: CSR updates, trap/mret redirects,
// and the 64-bit mcycle/minstret counters.
module csr_trap_unit #(
  parameter int unsigned XLEN        = 32,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
  input  logic           clk_i,
  input  logic           rst_i,
  csr_trap_unit_if.slave bus
);
  localparam int unsigned W  = XLEN;
  localparam int unsigned CW = 32;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [1:0] WT_NONE  = 2'b00;
  localparam logic [1:0] WT_WRITE = 2'b01;
  localparam logic [1:0] WT_SET   = 2'b10;
  localparam logic [1:0] WT_CLEAR = 2'b11;

  localparam logic [W-1:0] ALIGN_MASK = ~W'(3);

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_e;

  state_e state_q, state_d;

  logic         mie_q, mpie_q;
  logic [W-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, redirect_pc_q;
  logic [63:0]  mcycle_q, minstret_q;

  logic [W-1:0] csr_old, csr_new, trap_cause, trap_tval;
  logic         csr_hit, csr_illegal;
  logic         commit, take_trap, take_mret, retire, csr_we, redirect_valid;

  // Readback of the pre-write value; also the operand for set/clear
  always_comb begin
    csr_old = '0;
    csr_hit = 1'b1;
    case (bus.wb_csr_addr_i)
      CSR_MSTATUS:   csr_old = W'({19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0});
      CSR_MISA:      csr_old = W'(MISA_VALUE);
      CSR_MTVEC:     csr_old = mtvec_q & ALIGN_MASK;
      CSR_MSCRATCH:  csr_old = mscratch_q;
      CSR_MEPC:      csr_old = mepc_q & ALIGN_MASK;
      CSR_MCAUSE:    csr_old = mcause_q;
      CSR_MTVAL:     csr_old = mtval_q;
      CSR_MCYCLE:    csr_old = mcycle_q[CW-1:0];
      CSR_MCYCLEH:   csr_old = mcycle_q[63:CW];
      CSR_MINSTRET:  csr_old = minstret_q[CW-1:0];
      CSR_MINSTRETH: csr_old = minstret_q[63:CW];
      CSR_MHARTID:   csr_old = '0;
      default:       csr_hit = 1'b0;
    endcase
  end

  always_comb begin
    case (bus.wb_csr_wtype_i)
      WT_WRITE: csr_new = bus.wb_csr_wdata_i;
      WT_SET:   csr_new = csr_old | bus.wb_csr_wdata_i;
      WT_CLEAR: csr_new = csr_old & ~bus.wb_csr_wdata_i;
      default:  csr_new = csr_old;
    endcase
  end

  // Writes into the read-only address space count as illegal instructions
  assign csr_illegal = (bus.wb_csr_access_i && !csr_hit) ||
                       ((bus.wb_csr_wtype_i != WT_NONE) && (bus.wb_csr_addr_i[11:10] == 2'b11));

  assign take_trap  = commit && (bus.wb_trap_valid_i || csr_illegal);
  assign take_mret  = commit && !take_trap && bus.wb_is_mret_i;
  assign retire     = commit && !take_trap;
  assign csr_we     = retire && !bus.wb_is_mret_i && (bus.wb_csr_wtype_i != WT_NONE);
  assign trap_cause = bus.wb_trap_valid_i ? W'({1'b0, bus.wb_trap_code_i}) : W'(2);
  assign trap_tval  = bus.wb_trap_valid_i ? bus.wb_trap_tval_i : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (take_trap || take_mret) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // FLUSH swallows the wrong-path instruction and drives the redirect pulse
  always_comb begin
    commit         = 1'b0;
    redirect_valid = 1'b0;
    case (state_q)
      ST_RUN:   commit = bus.wb_valid_i;
      ST_FLUSH: redirect_valid = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      mtvec_q       <= W'(MTVEC_RESET);
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      redirect_pc_q <= '0;
    end else if (take_trap) begin
      mepc_q        <= bus.wb_pc_i;
      mcause_q      <= trap_cause;
      mtval_q       <= trap_tval;
      mpie_q        <= mie_q;
      mie_q         <= 1'b0;
      redirect_pc_q <= mtvec_q & ALIGN_MASK;
    end else if (take_mret) begin
      mie_q         <= mpie_q;
      mpie_q        <= 1'b1;
      redirect_pc_q <= mepc_q & ALIGN_MASK;
    end else if (csr_we) begin
      case (bus.wb_csr_addr_i)
        CSR_MSTATUS: begin
          mie_q  <= csr_new[3];
          mpie_q <= csr_new[7];
        end
        CSR_MTVEC:    mtvec_q    <= csr_new;
        CSR_MSCRATCH: mscratch_q <= csr_new;
        CSR_MEPC:     mepc_q     <= csr_new;
        CSR_MCAUSE:   mcause_q   <= csr_new;
        CSR_MTVAL:    mtval_q    <= csr_new;
        default:      ;
      endcase
    end
  end

  // A write to either half freezes the whole counter for that cycle
  always_ff @(posedge clk_i) begin
    if (rst_i)                                         mcycle_q <= '0;
    else if (csr_we && bus.wb_csr_addr_i == CSR_MCYCLE)  mcycle_q <= {mcycle_q[63:CW], csr_new};
    else if (csr_we && bus.wb_csr_addr_i == CSR_MCYCLEH) mcycle_q <= {csr_new, mcycle_q[CW-1:0]};
    else                                               mcycle_q <= mcycle_q + 64'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                                             minstret_q <= '0;
    else if (csr_we && bus.wb_csr_addr_i == CSR_MINSTRET)  minstret_q <= {minstret_q[63:CW], csr_new};
    else if (csr_we && bus.wb_csr_addr_i == CSR_MINSTRETH) minstret_q <= {csr_new, minstret_q[CW-1:0]};
    else if (retire)                                       minstret_q <= minstret_q + 64'd1;
  end

  assign bus.csr_rdata_o      = csr_old;
  assign bus.redirect_valid_o = redirect_valid;
  assign bus.redirect_pc_o    = redirect_pc_q;
  assign bus.mie_o            = mie_q;
endmodule

// File: tb/tb_csr_trap_unit.sv
// Bench for csr_trap_unit: directed vector table for the corner cases, then random
// commits checked against a spec-level model of the machine CSRs.
module tb_csr_trap_unit;
  typedef struct packed {
    logic        rst;
    logic        valid;
    logic [31:0] pc;
    logic        trap;
    logic [30:0] code;
    logic [31:0] tval;
    logic [11:0] addr;
    logic [1:0]  wtype;
    logic        access;
    logic [31:0] wdata;
    logic        mret;
  } stim_t;

  typedef struct {
    stim_t       s;
    bit          chk_rd;
    logic [31:0] exp_rd;
    bit          exp_rv;
    logic [31:0] exp_rpc;
    bit          chk_rpc;
    bit          exp_mie;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  csr_trap_unit_if bus ();

  csr_trap_unit #(
    .XLEN       (32),
    .MTVEC_RESET(32'h0000_0000),
    .MISA_VALUE (32'h4000_0100)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
    $fatal(1);
  end

  // Reference model: architectural CSR contents after each clock edge
  bit          m_flush, m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_rpc;
  logic [63:0] m_cycle, m_instret;

  task automatic model_reset();
    m_flush = 0; m_mie = 0; m_mpie = 0;
    m_mtvec = 32'h0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_rpc = 0;
    m_cycle = 0; m_instret = 0;
  endtask

  function automatic bit m_known(logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
      12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
      12'h301: return 32'h4000_0100;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'hB00: return m_cycle[31:0];
      12'hB80: return m_cycle[63:32];
      12'hB02: return m_instret[31:0];
      12'hB82: return m_instret[63:32];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step(input stim_t s);
    logic [31:0] old, nv;
    bit commit, illegal, cyc_w, ins_w, ins_inc;
    if (s.rst) begin
      model_reset();
      return;
    end
    old     = m_read(s.addr);
    commit  = !m_flush && s.valid;
    illegal = (s.access && !m_known(s.addr)) || (s.wtype != 2'b00 && s.addr[11:10] == 2'b11);
    cyc_w = 0; ins_w = 0; ins_inc = 0;
    m_flush = 0;
    case (s.wtype)
      2'b01:   nv = s.wdata;
      2'b10:   nv = old | s.wdata;
      2'b11:   nv = old & ~s.wdata;
      default: nv = old;
    endcase
    if (commit && (s.trap || illegal)) begin
      m_rpc    = m_mtvec;
      m_mepc   = s.pc & ~32'h3;
      m_mcause = s.trap ? {1'b0, s.code} : 32'd2;
      m_mtval  = s.trap ? s.tval : 32'd0;
      m_mpie   = m_mie;
      m_mie    = 0;
      m_flush  = 1;
    end else if (commit && s.mret) begin
      m_rpc   = m_mepc;
      m_mie   = m_mpie;
      m_mpie  = 1;
      m_flush = 1;
      ins_inc = 1;
    end else if (commit) begin
      ins_inc = 1;
      if (s.wtype != 2'b00) begin
        case (s.addr)
          12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h305: m_mtvec    = nv & ~32'h3;
          12'h340: m_mscratch = nv;
          12'h341: m_mepc     = nv & ~32'h3;
          12'h342: m_mcause   = nv;
          12'h343: m_mtval    = nv;
          12'hB00: begin m_cycle[31:0]    = nv; cyc_w = 1; end
          12'hB80: begin m_cycle[63:32]   = nv; cyc_w = 1; end
          12'hB02: begin m_instret[31:0]  = nv; ins_w = 1; end
          12'hB82: begin m_instret[63:32] = nv; ins_w = 1; end
          default: ;
        endcase
      end
    end
    if (!cyc_w) m_cycle = m_cycle + 64'd1;
    if (ins_inc && !ins_w) m_instret = m_instret + 64'd1;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic drive(input stim_t s);
    rst                 = s.rst;
    bus.wb_valid_i      = s.valid;
    bus.wb_pc_i         = s.pc;
    bus.wb_trap_valid_i = s.trap;
    bus.wb_trap_code_i  = s.code;
    bus.wb_trap_tval_i  = s.tval;
    bus.wb_csr_addr_i   = s.addr;
    bus.wb_csr_wtype_i  = s.wtype;
    bus.wb_csr_access_i = s.access;
    bus.wb_csr_wdata_i  = s.wdata;
    bus.wb_is_mret_i    = s.mret;
  endtask

  // Called at a falling edge; applies one cycle of stimulus and checks both sides of the edge
  task automatic do_cycle(input stim_t s, input bit use_v, input vec_t v, input int idx);
    drive(s);
    #1;
    check($sformatf("model rdata cyc%0d addr %h", idx, s.addr), bus.csr_rdata_o, m_read(s.addr));
    if (use_v && v.chk_rd) check($sformatf("vec%0d rdata", idx), bus.csr_rdata_o, v.exp_rd);
    model_step(s);
    @(negedge clk);
    check($sformatf("model redirect_valid cyc%0d", idx), 32'(bus.redirect_valid_o), 32'(m_flush));
    if (m_flush) check($sformatf("model redirect_pc cyc%0d", idx), bus.redirect_pc_o, m_rpc);
    check($sformatf("model mie cyc%0d", idx), 32'(bus.mie_o), 32'(m_mie));
    if (use_v) begin
      check($sformatf("vec%0d redirect_valid", idx), 32'(bus.redirect_valid_o), 32'(v.exp_rv));
      check($sformatf("vec%0d mie", idx), 32'(bus.mie_o), 32'(v.exp_mie));
      if (v.exp_rv || v.chk_rpc) check($sformatf("vec%0d redirect_pc", idx), bus.redirect_pc_o, v.exp_rpc);
    end
  endtask

  function automatic stim_t s_idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t s_csr(logic [11:0] a, logic [1:0] wt, logic [31:0] wd);
    stim_t s;
    s = '0;
    s.valid = 1; s.access = 1; s.addr = a; s.wtype = wt; s.wdata = wd; s.pc = 32'h1000;
    return s;
  endfunction

  function automatic stim_t s_at(stim_t si, logic [31:0] pc);
    stim_t s;
    s = si;
    s.pc = pc;
    return s;
  endfunction

  function automatic stim_t s_trap(logic [31:0] pc, logic [30:0] code);
    stim_t s;
    s = '0;
    s.valid = 1; s.trap = 1; s.pc = pc; s.code = code;
    return s;
  endfunction

  function automatic stim_t s_mret();
    stim_t s;
    s = '0;
    s.valid = 1; s.mret = 1;
    return s;
  endfunction

  function automatic stim_t s_rst();
    stim_t s;
    s = '0;
    s.rst = 1;
    return s;
  endfunction

  function automatic vec_t mk(stim_t s, bit crd, logic [31:0] rd, bit rv, logic [31:0] rpc,
                              bit crpc, bit mie);
    vec_t v;
    v.s = s; v.chk_rd = crd; v.exp_rd = rd; v.exp_rv = rv;
    v.exp_rpc = rpc; v.chk_rpc = crpc; v.exp_mie = mie;
    return v;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s = '0;
    s.rst   = ($urandom_range(0, 199) == 0);
    s.valid = ($urandom_range(0, 3) != 0);
    s.pc    = $urandom;
    s.trap  = ($urandom_range(0, 15) == 0);
    case ($urandom_range(0, 3))
      0:       s.code = 31'd2;
      1:       s.code = 31'd3;
      2:       s.code = 31'd11;
      default: s.code = 31'($urandom);
    endcase
    s.tval = $urandom;
    case ($urandom_range(0, 15))
      0:       s.addr = 12'h300;
      1:       s.addr = 12'h301;
      2:       s.addr = 12'h305;
      3:       s.addr = 12'h340;
      4:       s.addr = 12'h341;
      5:       s.addr = 12'h342;
      6:       s.addr = 12'h343;
      7:       s.addr = 12'hB00;
      8:       s.addr = 12'hB80;
      9:       s.addr = 12'hB02;
      10:      s.addr = 12'hB82;
      11:      s.addr = 12'hF14;
      12:      s.addr = 12'h7C0;
      13:      s.addr = 12'hC00;
      default: s.addr = 12'($urandom_range(0, 4095));
    endcase
    s.wtype  = 2'($urandom_range(0, 3));
    s.access = ($urandom_range(0, 3) != 0);
    s.wdata  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
    s.mret   = ($urandom_range(0, 15) == 0);
    return s;
  endfunction

  vec_t vq[$];
  vec_t dummy;

  initial begin
    total = 0;
    bad   = 0;
    dummy = mk(s_idle(), 0, 0, 0, 0, 0, 0);

    // mscratch raw write then set, minstret counting
    vq.push_back(mk(s_csr(12'h340, 2'b01, 32'hDEAD_BEEF), 1, 32'h0,        0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'h340, 2'b10, 32'h10),        1, 32'hDEAD_BEEF, 0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'h340, 2'b00, 32'h0),         1, 32'hDEAD_BEFF, 0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'hB02, 2'b00, 32'h0),         1, 32'd3,        0, 0, 0, 0));
    // mtvec with low bits set, enable MIE, ecall, wrong-path write in FLUSH
    vq.push_back(mk(s_csr(12'h305, 2'b01, 32'h8000_0103), 1, 32'h0,        0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'h300, 2'b10, 32'h8),         1, 32'h1800,     0, 0, 0, 1));
    vq.push_back(mk(s_trap(32'h100, 31'd11),              0, 0, 1, 32'h8000_0100, 1, 0));
    vq.push_back(mk(s_csr(12'h340, 2'b01, 32'h1234_5678), 1, 32'hDEAD_BEFF, 0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'h340, 2'b00, 32'h0),         1, 32'hDEAD_BEFF, 0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'h341, 2'b00, 32'h0),         1, 32'h100,      0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'h342, 2'b00, 32'h0),         1, 32'd11,       0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'h300, 2'b00, 32'h0),         1, 32'h1880,     0, 0, 0, 0));
    // mret restores MIE from MPIE
    vq.push_back(mk(s_mret(),                             0, 0, 1, 32'h100, 1, 1));
    vq.push_back(mk(s_idle(),                             0, 0, 0, 0, 0, 1));
    vq.push_back(mk(s_csr(12'h300, 2'b00, 32'h0),         1, 32'h1888,     0, 0, 0, 1));
    vq.push_back(mk(s_csr(12'hB02, 2'b00, 32'h0),         1, 32'd12,       0, 0, 0, 1));
    // write to mhartid is illegal
    vq.push_back(mk(s_at(s_csr(12'hF14, 2'b01, 32'h5), 32'h200), 1, 32'h0, 1, 32'h8000_0100, 1, 0));
    vq.push_back(mk(s_idle(),                             0, 0, 0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'hB02, 2'b00, 32'h0),         1, 32'd13,       0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'h342, 2'b00, 32'h0),         1, 32'd2,        0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'h343, 2'b00, 32'h0),         1, 32'd0,        0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'h341, 2'b00, 32'h0),         1, 32'h200,      0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'hF14, 2'b00, 32'h0),         1, 32'h0,        0, 0, 0, 0));
    // read of unimplemented 0x7C0 is illegal, mtval cleared
    vq.push_back(mk(s_csr(12'h343, 2'b01, 32'hAAAA),      1, 32'h0,        0, 0, 0, 0));
    vq.push_back(mk(s_at(s_csr(12'h7C0, 2'b00, 32'h0), 32'h300), 0, 0, 1, 32'h8000_0100, 1, 0));
    vq.push_back(mk(s_idle(),                             0, 0, 0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'h343, 2'b00, 32'h0),         1, 32'd0,        0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'h342, 2'b00, 32'h0),         1, 32'd2,        0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'h341, 2'b00, 32'h0),         1, 32'h300,      0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'hB02, 2'b00, 32'h0),         1, 32'd22,       0, 0, 0, 0));
    // mcycle carry, write-over-increment, 64-bit wrap
    vq.push_back(mk(s_csr(12'hB00, 2'b01, 32'hFFFF_FFFF), 0, 0,            0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'hB80, 2'b01, 32'h0),         0, 0,            0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'hB00, 2'b00, 32'h0),         1, 32'hFFFF_FFFF, 0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'hB80, 2'b00, 32'h0),         1, 32'd1,        0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'hB00, 2'b00, 32'h0),         1, 32'd1,        0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'hB00, 2'b01, 32'h55),        1, 32'd2,        0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'hB00, 2'b00, 32'h0),         1, 32'h55,       0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'hB00, 2'b00, 32'h0),         1, 32'h56,       0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'hB80, 2'b01, 32'hFFFF_FFFF), 1, 32'd1,        0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'hB00, 2'b01, 32'hFFFF_FFFF), 1, 32'h57,       0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'hB80, 2'b00, 32'h0),         1, 32'hFFFF_FFFF, 0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'hB80, 2'b00, 32'h0),         1, 32'd0,        0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'hB00, 2'b00, 32'h0),         1, 32'd1,        0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'hB02, 2'b01, 32'h1000),      0, 0,            0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'hB02, 2'b00, 32'h0),         1, 32'h1000,     0, 0, 0, 0));
    // reset during FLUSH aborts the redirect
    vq.push_back(mk(s_csr(12'h340, 2'b01, 32'h77),        0, 0,            0, 0, 0, 0));
    vq.push_back(mk(s_trap(32'h400, 31'd11),              0, 0, 1, 32'h8000_0100, 1, 0));
    vq.push_back(mk(s_rst(),                              0, 0, 0, 32'h0, 1, 0));
    vq.push_back(mk(s_csr(12'hB02, 2'b00, 32'h0),         1, 32'd0,        0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'h340, 2'b00, 32'h0),         1, 32'd0,        0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'h305, 2'b00, 32'h0),         1, 32'd0,        0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'h300, 2'b00, 32'h0),         1, 32'h1800,     0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'h341, 2'b00, 32'h0),         1, 32'd0,        0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'h342, 2'b00, 32'h0),         1, 32'd0,        0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'h343, 2'b00, 32'h0),         1, 32'd0,        0, 0, 0, 0));
    vq.push_back(mk(s_csr(12'hB80, 2'b00, 32'h0),         1, 32'd0,        0, 0, 0, 0));

    drive(s_rst());
    repeat (2) @(negedge clk);
    model_reset();
    check("reset redirect_valid", 32'(bus.redirect_valid_o), 32'd0);
    check("reset redirect_pc", bus.redirect_pc_o, 32'h0);
    check("reset mie", 32'(bus.mie_o), 32'd0);

    foreach (vq[i]) do_cycle(vq[i].s, 1'b1, vq[i], i);

    for (int c = 0; c < 4000; c++) do_cycle(rand_stim(), 1'b0, dummy, 1000 + c);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Machine-mode CSR file and trap sequencer at the write-back/commit end of the pipeline.
- Consumes the per-instruction control that the decode stage produces and the pipeline carries to WB: trap valid/code, CSR write type, CSR write source data, and mret.
- Commits CSR updates and raises a registered one-cycle PC redirect on traps and mret.
- Maintains the 64-bit mcycle/minstret counters.

Parameters:
- XLEN, 32, data width; only 32 is supported.
- MTVEC_RESET, 32'h0000_0000, mtvec reset value; bits 1:0 are forced to 0.
- MISA_VALUE, 32'h4000_0100, read-only misa value (RV32I).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- wb_valid_i  in  1  an instruction commits this cycle
- wb_pc_i  in  32  PC of the committing instruction
- wb_trap_valid_i  in  1  decode/execute trap pending on this instruction
- wb_trap_code_i  in  31  trap cause code: 2 illegal, 3 breakpoint, 11 ecall-M
- wb_trap_tval_i  in  32  value for mtval
- wb_csr_addr_i  in  12  CSR address
- wb_csr_wtype_i  in  2  00 disable, 01 raw write, 10 set bits, 11 clear bits
- wb_csr_access_i  in  1  instruction is a CSR instruction; it reads even when the write is disabled
- wb_csr_wdata_i  in  32  write operand, already muxed from rs1 data or zimm
- wb_is_mret_i  in  1  instruction is mret
- csr_rdata_o  out  32  combinational old value of wb_csr_addr_i
- redirect_valid_o  out  1  registered one-cycle redirect/flush pulse
- redirect_pc_o  out  32  redirect target, valid with redirect_valid_o
- mie_o  out  1  mstatus.MIE

Behaviour:
- Implemented CSRs:
  - mstatus 0x300: MIE bit 3 and MPIE bit 7 are writable; MPP 12:11 reads 2'b11; all other bits read 0.
  - misa 0x301: read-only, returns MISA_VALUE.
  - mtvec 0x305: direct mode only; bits 1:0 read 0.
  - mscratch 0x340: full 32-bit read/write.
  - mepc 0x341: bits 1:0 read 0.
  - mcause 0x342: full 32-bit read/write.
  - mtval 0x343: full 32-bit read/write.
  - mcycle/mcycleh 0xB00/0xB80 and minstret/minstreth 0xB02/0xB82: read/write.
  - mhartid 0xF14: read-only, returns 0.
- Write value: raw gives wdata; set gives old|wdata; clear gives old&~wdata. Reads always return the pre-write value.
- CSR illegal: wb_csr_access_i with an unimplemented address, or wtype≠00 with addr[11:10]==2'b11. It is treated as a trap with code 2 and tval 0.
- States are RUN and FLUSH.
- In RUN, a commit (wb_valid_i=1) is resolved in priority order:
  1. Trap (wb_trap_valid_i or CSR illegal):
     - mepc←wb_pc_i, mcause←{1'b0,code}, mtval←tval, MPIE←MIE, MIE←0.
     - The CSR write is suppressed and minstret does not increment.
     - Next state FLUSH; redirect_pc_o←mtvec (value before this cycle's update).
  2. mret: MIE←MPIE, MPIE←1, redirect_pc_o←mepc; next state FLUSH; minstret increments.
  3. Otherwise: apply the CSR write if wtype≠00; minstret increments.
- FLUSH lasts exactly one cycle:
  - redirect_valid_o=1 during FLUSH.
  - wb_valid_i is ignored (it carries a wrong-path instruction).
  - The state then returns to RUN.
- Counters:
  - mcycle increments every cycle except the reset cycle.
  - A CSR write to mcycle or mcycleh replaces that half; neither half increments that cycle.
  - minstret follows the same rule; the write wins over the increment.
  - Increments carry from the low half into the high half; both wrap 2^64−1→0.
- Reset values:
  - All CSRs are 0, except mtvec=MTVEC_RESET and MPP=11.
  - State RUN, redirect_valid_o=0, redirect_pc_o=0, mie_o=0.
  - Reset asserted during FLUSH aborts the redirect in the same edge.
- A trap commit in the cycle directly after a trap is impossible, because FLUSH ignores it.

Test Plan:
- CSRRW mscratch, wdata 0xDEADBEEF, then CSRRS mscratch wdata 0x10 → second csr_rdata_o=0xDEADBEEF, mscratch=0xDEADBEFF, minstret +2.
- mtvec←0x80000103, then ecall commit at PC 0x100 → next cycle redirect_valid_o=1, redirect_pc_o=0x80000100; mepc=0x100, mcause=11, MIE=0; a wb_valid_i in the FLUSH cycle changes nothing.
- MIE=1, trap, then mret → MPIE=1 after the trap; mret redirects to mepc with MIE=1 and MPIE=1.
- CSRRW to mhartid, and separately a read of 0x7C0 → illegal trap: mcause=2, mtval=0, no write, minstret unchanged.
- Write mcycle=0xFFFFFFFF, mcycleh=0 → the following cycles show mcycleh=1 and mcycle wrapping; a same-cycle write overrides the increment.
- Assert rst_i during FLUSH → redirect_valid_o=0 next cycle and all CSRs at reset values.
